// File: rtl/panda_risc_v_lic_scoreboard.sv
// Long-instruction (load/mul/div) scoreboard: tag allocation at dispatch, release at writeback,
// combinational RAW/WAW checks. Optional macro LIC_WB_BYPASS_EN masks a releasing entry from the checks.
module panda_risc_v_lic_scoreboard #(
  parameter int simulation_delay = 1,
  parameter int LIC_DEPTH        = 4
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic [4:0] raw_dpc_check_rs1_id,
  output logic       rs1_raw_dpc,
  input  logic [4:0] raw_dpc_check_rs2_id,
  output logic       rs2_raw_dpc,
  input  logic [4:0] raw_dpc_check_rd_id,
  output logic       rd_waw_dpc,
  input  logic [4:0] s_lic_alloc_rd_id,
  input  logic       s_lic_alloc_valid,
  output logic       s_lic_alloc_ready,
  output logic [2:0] s_lic_alloc_tag,
  input  logic [2:0] s_lic_wb_tag,
  input  logic       s_lic_wb_valid,
  output logic [3:0] lic_cnt,
  output logic       lic_empty,
  output logic       lic_err
);

  // The simulation delay has no synthesizable meaning; it is kept only for interface compatibility.
  logic unused_sim_delay;
  assign unused_sim_delay = ^simulation_delay;

  logic [LIC_DEPTH-1:0]      entry_vld_q, entry_vld_d;
  logic [LIC_DEPTH-1:0][4:0] entry_rd_q, entry_rd_d;
  logic [3:0]                lic_cnt_q, lic_cnt_d;
  logic                      lic_err_q, lic_err_d;

  logic [LIC_DEPTH-1:0] wb_mask;
  logic [LIC_DEPTH-1:0] chk_vld;
  logic                 wb_hit;
  logic                 alloc_fire;
  logic                 free_found;

  // Free search and release decode both use the registered vector only.
  always_comb begin
    s_lic_alloc_tag = 3'd0;
    free_found      = 1'b0;
    wb_mask         = '0;
    for (int i = 0; i < LIC_DEPTH; i++) begin
      if (!entry_vld_q[i] && !free_found) begin
        s_lic_alloc_tag = 3'(i);
        free_found      = 1'b1;
      end
      if (s_lic_wb_tag == 3'(i) && entry_vld_q[i])
        wb_mask[i] = s_lic_wb_valid;
    end
  end

  assign s_lic_alloc_ready = ~&entry_vld_q;
  assign alloc_fire        = s_lic_alloc_valid & s_lic_alloc_ready;
  assign wb_hit            = |wb_mask;

`ifdef LIC_WB_BYPASS_EN
  assign chk_vld = entry_vld_q & ~wb_mask;
`else
  assign chk_vld = entry_vld_q;
`endif

  always_comb begin
    rs1_raw_dpc = 1'b0;
    rs2_raw_dpc = 1'b0;
    rd_waw_dpc  = 1'b0;
    for (int i = 0; i < LIC_DEPTH; i++) begin
      if (chk_vld[i] && entry_rd_q[i] == raw_dpc_check_rs1_id && raw_dpc_check_rs1_id != 5'd0)
        rs1_raw_dpc = 1'b1;
      if (chk_vld[i] && entry_rd_q[i] == raw_dpc_check_rs2_id && raw_dpc_check_rs2_id != 5'd0)
        rs2_raw_dpc = 1'b1;
      if (chk_vld[i] && entry_rd_q[i] == raw_dpc_check_rd_id && raw_dpc_check_rd_id != 5'd0)
        rd_waw_dpc = 1'b1;
    end
  end

  always_comb begin
    entry_vld_d = entry_vld_q & ~wb_mask;
    entry_rd_d  = entry_rd_q;
    for (int i = 0; i < LIC_DEPTH; i++) begin
      if (alloc_fire && s_lic_alloc_tag == 3'(i)) begin
        entry_vld_d[i] = 1'b1;
        entry_rd_d[i]  = s_lic_alloc_rd_id;
      end
    end
    unique case ({alloc_fire, wb_hit})
      2'b10:   lic_cnt_d = lic_cnt_q + 4'd1;
      2'b01:   lic_cnt_d = lic_cnt_q - 4'd1;
      default: lic_cnt_d = lic_cnt_q;
    endcase
    // Any strobe that does not hit a live entry (incl. out-of-range tags) is a protocol error.
    lic_err_d = lic_err_q | (s_lic_wb_valid & ~wb_hit);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      entry_vld_q <= '0;
      entry_rd_q  <= '0;
      lic_cnt_q   <= 4'd0;
      lic_err_q   <= 1'b0;
    end else begin
      entry_vld_q <= entry_vld_d;
      entry_rd_q  <= entry_rd_d;
      lic_cnt_q   <= lic_cnt_d;
      lic_err_q   <= lic_err_d;
    end
  end

  assign lic_cnt   = lic_cnt_q;
  assign lic_empty = (lic_cnt_q == 4'd0);
  assign lic_err   = lic_err_q;

endmodule

// File: tb/tb_panda_risc_v_lic_scoreboard.sv
// Bench for panda_risc_v_lic_scoreboard: directed scenarios plus random traffic vs. a table model.
module tb_panda_risc_v_lic_scoreboard;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [4:0] c1, c2, c3, ard;
  logic       av, wv;
  logic [2:0] wt;
  logic       rs1_f, rs2_f, rd_f, rdy, empty, err;
  logic [2:0] tag;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;

  // Reference: a plain table of in-flight writers.
  bit         mvld[D];
  logic [4:0] mrd[D];
  bit         merr;

  panda_risc_v_lic_scoreboard #(.simulation_delay(1), .LIC_DEPTH(D)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .raw_dpc_check_rs1_id(c1), .rs1_raw_dpc(rs1_f),
    .raw_dpc_check_rs2_id(c2), .rs2_raw_dpc(rs2_f),
    .raw_dpc_check_rd_id(c3), .rd_waw_dpc(rd_f),
    .s_lic_alloc_rd_id(ard), .s_lic_alloc_valid(av), .s_lic_alloc_ready(rdy),
    .s_lic_alloc_tag(tag), .s_lic_wb_tag(wt), .s_lic_wb_valid(wv),
    .lic_cnt(cnt), .lic_empty(empty), .lic_err(err)
  );

  always #5 clk = ~clk;

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mvld[i]);
    return n;
  endfunction

  function automatic int m_tag();
    for (int i = 0; i < D; i++) if (!mvld[i]) return i;
    return 0;
  endfunction

  function automatic bit m_rel_ok();
    return wv && int'(wt) < D && mvld[int'(wt)];
  endfunction

  function automatic bit m_flag(input logic [4:0] id);
    bit masked;
    for (int i = 0; i < D; i++) begin
`ifdef LIC_WB_BYPASS_EN
      masked = wv && int'(wt) == i;
`else
      masked = 1'b0;
`endif
      if (mvld[i] && mrd[i] == id && id != 5'd0 && !masked) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_in(input bit a, input logic [4:0] r, input bit w, input logic [2:0] t);
    av = a; ard = r; wv = w; wt = t;
  endtask

  // One clock: model applies the same rules at the edge, then inputs idle.
  task automatic tick();
    int  ftag;
    bit  fire, rel;
    @(posedge clk);
    if (sys_rst) begin
      for (int i = 0; i < D; i++) mvld[i] = 1'b0;
      merr = 1'b0;
    end else begin
      fire = av && m_cnt() < D;
      ftag = m_tag();
      rel  = m_rel_ok();
      if (wv && !rel) merr = 1'b1;
      if (rel) mvld[int'(wt)] = 1'b0;
      if (fire) begin mvld[ftag] = 1'b1; mrd[ftag] = ard; end
    end
    #1;
    set_in(1'b0, 5'd0, 1'b0, 3'd0);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    c1 = 5'd5; c2 = 5'd1; c3 = 5'd31;
    do_reset();
    total += 8;
    if (rdy !== 1'b1)   begin bad++; $display("FAIL reset_ready got=%b exp=1", rdy); end
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (cnt !== 4'd0)   begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    if (tag !== 3'd0)   begin bad++; $display("FAIL reset_tag got=%0d exp=0", tag); end
    if (rs1_f !== 1'b0) begin bad++; $display("FAIL reset_rs1 got=%b exp=0", rs1_f); end
    if (rs2_f !== 1'b0) begin bad++; $display("FAIL reset_rs2 got=%b exp=0", rs2_f); end
    if (rd_f !== 1'b0)  begin bad++; $display("FAIL reset_rd got=%b exp=0", rd_f); end
  endtask

  task automatic test_alloc_basic();
    do_reset();
    set_in(1'b1, 5'd5, 1'b0, 3'd0); #1;
    total++; if (tag !== 3'd0) begin bad++; $display("FAIL basic_tag got=%0d exp=0", tag); end
    tick();
    c1 = 5'd5; c2 = 5'd0; c3 = 5'd5; #1;
    total += 4;
    if (cnt !== 4'd1)   begin bad++; $display("FAIL basic_cnt got=%0d exp=1", cnt); end
    if (rs1_f !== 1'b1) begin bad++; $display("FAIL basic_rs1 got=%b exp=1", rs1_f); end
    if (rs2_f !== 1'b0) begin bad++; $display("FAIL basic_rs2_x0 got=%b exp=0", rs2_f); end
    if (rd_f !== 1'b1)  begin bad++; $display("FAIL basic_rd got=%b exp=1", rd_f); end
    // rd=0 allocations take a tag but never match
    set_in(1'b1, 5'd0, 1'b0, 3'd0); tick();
    c1 = 5'd0; c3 = 5'd0; #1;
    total += 3;
    if (cnt !== 4'd2)   begin bad++; $display("FAIL rd0_cnt got=%0d exp=2", cnt); end
    if (rs1_f !== 1'b0) begin bad++; $display("FAIL rd0_rs1 got=%b exp=0", rs1_f); end
    if (rd_f !== 1'b0)  begin bad++; $display("FAIL rd0_rd got=%b exp=0", rd_f); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 5'(i + 1), 1'b0, 3'd0); #1;
      total++; if (tag !== 3'(i)) begin bad++; $display("FAIL full_tag%0d got=%0d exp=%0d", i, tag, i); end
      tick();
    end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", rdy); end
    set_in(1'b1, 5'd20, 1'b0, 3'd0); tick();
    c1 = 5'd20; #1;
    total += 2;
    if (cnt !== 4'd4)   begin bad++; $display("FAIL full_cnt got=%0d exp=4", cnt); end
    if (rs1_f !== 1'b0) begin bad++; $display("FAIL full_noalloc got=%b exp=0", rs1_f); end
  endtask

  task automatic test_release_when_full();
    set_in(1'b1, 5'd9, 1'b1, 3'd2); #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL relfull_ready got=%b exp=0", rdy); end
    tick();
    c1 = 5'd9; c2 = 5'd3; #1;
    total += 5;
    if (tag !== 3'd2)   begin bad++; $display("FAIL relfull_tag got=%0d exp=2", tag); end
    if (cnt !== 4'd3)   begin bad++; $display("FAIL relfull_cnt got=%0d exp=3", cnt); end
    if (rdy !== 1'b1)   begin bad++; $display("FAIL relfull_ready2 got=%b exp=1", rdy); end
    if (rs1_f !== 1'b0) begin bad++; $display("FAIL relfull_rd9 got=%b exp=0", rs1_f); end
    if (rs2_f !== 1'b0) begin bad++; $display("FAIL relfull_rd3 got=%b exp=0", rs2_f); end
  endtask

  task automatic test_simul();
    do_reset();
    set_in(1'b1, 5'd3, 1'b0, 3'd0); tick();
    set_in(1'b1, 5'd7, 1'b0, 3'd0); tick();
    set_in(1'b0, 5'd0, 1'b1, 3'd0); tick();
    set_in(1'b1, 5'd8, 1'b1, 3'd1); #1;
    total++; if (tag !== 3'd0) begin bad++; $display("FAIL simul_tag got=%0d exp=0", tag); end
    tick();
    c1 = 5'd7; c2 = 5'd8; #1;
    total += 3;
    if (cnt !== 4'd1)   begin bad++; $display("FAIL simul_cnt got=%0d exp=1", cnt); end
    if (rs1_f !== 1'b0) begin bad++; $display("FAIL simul_rd7 got=%b exp=0", rs1_f); end
    if (rs2_f !== 1'b1) begin bad++; $display("FAIL simul_rd8 got=%b exp=1", rs2_f); end
  endtask

  task automatic test_err();
    do_reset();
    set_in(1'b0, 5'd0, 1'b1, 3'd3); tick();
    total += 2;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    if (cnt !== 4'd0) begin bad++; $display("FAIL err_cnt got=%0d exp=0", cnt); end
    set_in(1'b1, 5'd6, 1'b0, 3'd0); tick();
    set_in(1'b0, 5'd0, 1'b1, 3'd6); tick();
    c1 = 5'd6; #1;
    total += 3;
    if (err !== 1'b1)   begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    if (cnt !== 4'd1)   begin bad++; $display("FAIL err_oor_cnt got=%0d exp=1", cnt); end
    if (rs1_f !== 1'b1) begin bad++; $display("FAIL err_entry got=%b exp=1", rs1_f); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    // late writeback for an entry dropped by reset
    set_in(1'b0, 5'd0, 1'b1, 3'd0); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_late got=%b exp=1", err); end
  endtask

  task automatic test_bypass();
    bit exp_same;
    do_reset();
    set_in(1'b1, 5'd12, 1'b0, 3'd0); tick();
    c1 = 5'd12;
    set_in(1'b0, 5'd0, 1'b1, 3'd0); #1;
`ifdef LIC_WB_BYPASS_EN
    exp_same = 1'b0;
`else
    exp_same = 1'b1;
`endif
    total++; if (rs1_f !== exp_same) begin bad++; $display("FAIL bypass_same got=%b exp=%b", rs1_f, exp_same); end
    tick();
    total++; if (rs1_f !== 1'b0) begin bad++; $display("FAIL bypass_next got=%b exp=0", rs1_f); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sys_rst = ($urandom_range(0, 63) == 0);
      c1 = 5'($urandom_range(0, 7)); c2 = 5'($urandom_range(0, 7)); c3 = 5'($urandom_range(0, 7));
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, D - 1)));
      #1;
      total += 7;
      if (rdy !== (m_cnt() < D))         begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, rdy, m_cnt() < D); end
      if (cnt !== 4'(m_cnt()))           begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, cnt, m_cnt()); end
      if (empty !== (m_cnt() == 0))      begin bad++; $display("FAIL rnd_empty n=%0d got=%b", n, empty); end
      if (err !== merr)                  begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, merr); end
      if (rs1_f !== m_flag(c1))          begin bad++; $display("FAIL rnd_rs1 n=%0d got=%b exp=%b", n, rs1_f, m_flag(c1)); end
      if (rs2_f !== m_flag(c2))          begin bad++; $display("FAIL rnd_rs2 n=%0d got=%b exp=%b", n, rs2_f, m_flag(c2)); end
      if (rd_f !== m_flag(c3))           begin bad++; $display("FAIL rnd_rd n=%0d got=%b exp=%b", n, rd_f, m_flag(c3)); end
      if (m_cnt() < D) begin
        total++;
        if (tag !== 3'(m_tag())) begin bad++; $display("FAIL rnd_tag n=%0d got=%0d exp=%0d", n, tag, m_tag()); end
      end
      tick();
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    c1 = '0; c2 = '0; c3 = '0;
    set_in(1'b0, 5'd0, 1'b0, 3'd0);
    merr = 1'b0;
    for (int i = 0; i < D; i++) begin mvld[i] = 1'b0; mrd[i] = 5'd0; end
    test_reset();
    test_alloc_basic();
    test_full();
    test_release_when_full();
    test_simul();
    test_err();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/panda_risc_v_lic_scoreboard.md
Name: panda_risc_v_lic_scoreboard

Overview:
- Scoreboard for long instructions in flight: loads, multiply and divide. These are dispatched but not yet written back to the general register file.
- Sits beside the decoder/dispatcher. Answers its combinational RAW checks (RS1, RS2) and WAW check (RD).
- Each long instruction allocates an entry at dispatch and receives a tag. The entry is released when the EXU writes back with that tag.

Parameters:
- simulation_delay, 1, register update delay for simulation.
- LIC_DEPTH, 4, number of scoreboard entries (2..8).

Ports:
- clk  input  1  clock.
- sys_rst  input  1  reset, synchronous, active-high.
- raw_dpc_check_rs1_id  input  5  RS1 index to check.
- rs1_raw_dpc  output  1  RS1 has pending writer.
- raw_dpc_check_rs2_id  input  5  RS2 index to check.
- rs2_raw_dpc  output  1  RS2 has pending writer.
- raw_dpc_check_rd_id  input  5  RD index to check.
- rd_waw_dpc  output  1  RD has pending writer.
- s_lic_alloc_rd_id  input  5  RD of dispatched long instruction.
- s_lic_alloc_valid  input  1  allocation request.
- s_lic_alloc_ready  output  1  free entry available.
- s_lic_alloc_tag  output  3  tag of the entry being allocated.
- s_lic_wb_tag  input  3  tag of the written-back long instruction.
- s_lic_wb_valid  input  1  writeback/release strobe.
- lic_cnt  output  4  number of valid entries.
- lic_empty  output  1  no entry valid.
- lic_err  output  1  sticky: release of an invalid entry or an out-of-range tag.

Behaviour:
- State:
  - entry_vld[LIC_DEPTH-1:0] and entry_rd[i][4:0].
  - lic_cnt register.
  - lic_err register.
- Reset (sys_rst=1 at posedge):
  - all entry_vld=0, lic_cnt=0, lic_err=0.
  - Resulting outputs: s_lic_alloc_ready=1, lic_empty=1, all dpc flags=0, s_lic_alloc_tag=0.
- Dependency checks are purely combinational (0-cycle):
  - flag = OR over i of (entry_vld[i] && entry_rd[i]==id && id!=0).
  - Index 0 never reports a dependency.
- Allocation:
  - s_lic_alloc_ready = ~&entry_vld, using the registered vector.
  - s_lic_alloc_tag = lowest index with entry_vld==0. When full it is 0 and must be ignored.
  - Handshake on alloc_valid && alloc_ready: at the next posedge, entry_vld[tag]=1 and entry_rd[tag]=alloc_rd_id.
  - Alloc with rd=0 is accepted and a tag is issued, but the entry never matches a check.
  - Duplicate RD across entries is permitted.
  - alloc_valid while full: no state change. The requester holds.
- Release:
  - On wb_valid with entry_vld[wb_tag]=1: entry_vld[wb_tag]=0 at the next posedge.
  - Invalid entry or wb_tag>=LIC_DEPTH: no state change, lic_err set until reset.
- Simultaneous alloc and release in the same cycle:
  - Both take effect.
  - The released entry is not reusable until the following cycle, because the free search uses the registered vector.
  - lic_cnt unchanged.
- lic_cnt update: +1 on alloc only, -1 on a valid release only, unchanged on both or neither. It never exceeds LIC_DEPTH.
- lic_empty = (lic_cnt==0).
- No flush input:
  - Dispatched long instructions always write back, so flush never clears entries.
  - The pipeline flush waits on lic_empty where it needs to.
- Reset mid-operation: all entries are dropped. Late writebacks after reset are invalid releases and set lic_err.

Optional Feature:
- Macro: LIC_WB_BYPASS_EN.
- Defined:
  - A valid release in the current cycle masks its entry from all three checks combinationally.
  - A dependency clears in the same cycle as the writeback.
  - s_lic_alloc_ready and s_lic_alloc_tag still use the registered vector.
- Undefined: checks use only registered entry_vld, so a dependency clears one cycle after the writeback strobe.

Test Plan:
1. Reset, then alloc rd=5 -> tag=0 and lic_cnt=1. Check rs1=5 -> rs1_raw_dpc=1. Check rs2=0 -> 0. Check rd=5 -> rd_waw_dpc=1.
2. Allocate LIC_DEPTH=4 entries with rd 1..4 -> tags 0,1,2,3, then ready=0. A 5th alloc_valid -> no change, lic_cnt=4.
3. Full table; release tag 2 together with alloc rd=9 -> alloc not taken (ready=0). Next cycle tag=2 is offered and lic_cnt=3.
4. One entry valid (tag 1, rd 7); release tag 1 together with alloc rd=8 (tag 0) -> lic_cnt unchanged. Next cycle check rd 7 -> 0 and rd 8 -> 1.
5. Release tag 3 while empty -> lic_err=1 and stays 1 until sys_rst; entries unaffected.
6. LIC_WB_BYPASS_EN defined, entry rd=12; writeback strobe for it -> rs1_raw_dpc for 12 drops in the same cycle. Undefined -> drops one cycle later.
